attopu_loader: RTL and testbench
================================

# attopu_loader

Boot-time program loader for the attopu processor. Accepts a framed byte stream over a valid/ready handshake, assembles 16-bit instruction words, and writes them sequentially into instruction memory from address 0. The processor is held in reset (`cpu_rst`) until a frame completes with a correct checksum. This block is the write side of the instruction memory the processor reads through `PC`/`instruction`.

## Interface

Parameters:
- `ADDR_W`, default 8: instruction memory address width. The maximum word count is min(255, 2^ADDR_W).

Ports:
- `clk` in, 1 bit: clock; all state updates on the rising edge.
- `rst` in, 1 bit: reset, asynchronous and active-low.
- `in_data` in, 8 bits: stream byte.
- `in_valid` in, 1 bit: `in_data` is valid.
- `in_ready` out, 1 bit: the loader can accept a byte this cycle.
- `mem_we` out, 1 bit: instruction memory write strobe, one-cycle pulse.
- `mem_addr` out, `ADDR_W` bits: write address.
- `mem_wdata` out, 16 bits: write data.
- `cpu_rst` out, 1 bit: active-high reset to the processor's `rst`.
- `done` out, 1 bit: last frame loaded and verified.
- `err` out, 1 bit: last frame rejected.

## Operation

- **Frame format:** `0xA5` sync, count byte N (words), then N words sent high byte first then low byte, then a checksum byte.
- **Checksum:** XOR of all 2N payload bytes. The sync and count bytes are excluded.
- **Accept condition:** a byte is accepted on a rising edge with `in_valid && in_ready`. Bytes are consumed only on acceptance.
- **States:**
  - IDLE: accepted `0xA5` -> COUNT, clear checksum accumulator and word index. Any other byte is discarded and the state stays IDLE.
  - COUNT: N == 0 or N > 2^ADDR_W -> ERR. Otherwise latch N -> HI.
  - HI: latch the byte into `mem_wdata[15:8]` -> LO.
  - LO: latch the byte into `mem_wdata[7:0]`, set `mem_addr` = word index -> WRITE.
  - WRITE: `mem_we`=1 for exactly this cycle, `in_ready`=0, increment the word index. If the index has reached N -> CHK, else -> HI.
  - CHK: byte == accumulator -> DONE, otherwise -> ERR.
  - DONE: `done`=1, `cpu_rst`=0. An accepted `0xA5` -> COUNT: `cpu_rst`=1, `done`=0 (reload). Other bytes are discarded.
  - ERR: `err`=1, `cpu_rst`=1. An accepted `0xA5` -> COUNT: `err`=0. Other bytes are discarded.
- **`in_ready`:** 1 in every state except WRITE. Forced to 0 while `rst` is low.
- **`cpu_rst`:** remains 1 from reset until DONE is entered. It is never released on an error.
- **Memory contents:** words written before an error remain in memory. The loader does not erase them.
- **Counters:** word index is `ADDR_W`+1 bits wide, so there is no wrap. The checksum accumulator is 8 bits.

## Timing

- **Reset values (asynchronous, `rst` low):** state IDLE, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `cpu_rst`=1, `done`=0, `err`=0, `in_ready`=0.
- **After reset release:** `in_ready`=1 from the first cycle after `rst` is sampled high.
- **Write latency:** LO byte accepted at edge k -> `mem_we`=1 with stable `mem_addr`/`mem_wdata` between edges k and k+1. The memory captures the word at edge k+1. `in_ready`=0 during that same interval.
- **Throughput:** 3 cycles per word minimum (HI, LO, WRITE).
- **Completion:** checksum byte accepted at edge k -> `done`/`err`/`cpu_rst` hold their new values from edge k. All outputs are registered, with no combinational path from `in_data`.
- **Reset mid-frame:** immediate return to reset values. Partial words are never written, and `mem_we` drops asynchronously.
- **Stalls:** gaps in `in_valid` in any state leave all state and outputs unchanged. No timeout.

## Test plan

1. **Reset:** hold `rst`=0 for 3 cycles -> `cpu_rst`=1, `done`=0, `err`=0, `mem_we`=0, `in_ready`=0. Release -> `in_ready`=1 after one cycle.
2. **Good load:** stream A5 02 12 34 AB CD 40 -> exactly two `mem_we` pulses, (addr 0, 0x1234) then (addr 1, 0xABCD). Then `done`=1, `cpu_rst`=0, `err`=0.
3. **Bad checksum:** stream A5 02 12 34 AB CD 41 -> two writes, then `err`=1, `cpu_rst`=1, `done`=0. Then stream A5 01 00 0F 0F -> `err`=0, write (0, 0x000F), `done`=1.
4. **Pre-sync garbage and bad count:** stream 00 FF 5A before a good frame -> no writes before sync, and the frame loads as in scenario 2. Stream A5 00 -> `err`=1 with no writes.
5. **Backpressure and gaps:** drive `in_valid` continuously -> `in_ready`=0 exactly on each WRITE cycle, and no byte is lost or duplicated. Insert random `in_valid` gaps -> identical memory image.
6. **Reset mid-load:** assert `rst` after word 0 of a 2-word frame -> reset values immediately, and no further writes. A subsequent full frame loads correctly from addr 0.

Source files
------------

// File: rtl/attopu_loader.sv
// rtl/attopu_loader.sv - boot-time framed byte-stream loader for attopu instruction memory
module attopu_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_wdata,
    output logic              cpu_rst,
    output logic              done,
    output logic              err
);

    localparam int          IDX_W = ADDR_W + 1;
    localparam logic [31:0] MAX_N = 32'd1 << ADDR_W;
    localparam logic [7:0]  SYNC  = 8'hA5;

    typedef enum logic [2:0] {
        S_IDLE,
        S_COUNT,
        S_HI,
        S_LO,
        S_WRITE,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t            r_state;
    logic [IDX_W-1:0]  r_idx;
    logic [IDX_W-1:0]  r_count;
    logic [7:0]        r_csum;
    logic              r_in_ready;
    logic              r_mem_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [15:0]       r_mem_wdata;
    logic              r_cpu_rst;
    logic              r_done;
    logic              r_err;

    logic              w_accept;
    logic              w_sync;
    logic              w_bad_count;
    logic [IDX_W-1:0]  w_idx_next;

    assign w_accept    = in_valid && r_in_ready;
    assign w_sync      = (in_data == SYNC);
    assign w_bad_count = (in_data == 8'd0) || ({24'd0, in_data} > MAX_N);
    assign w_idx_next  = r_idx + IDX_W'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_idx       <= '0;
            r_count     <= '0;
            r_csum      <= '0;
            r_in_ready  <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_rst   <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            // Only the LO->WRITE transition withholds ready or raises the strobe.
            r_mem_we   <= 1'b0;
            r_in_ready <= 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (w_accept && w_sync) begin
                        r_state <= S_COUNT;
                        r_csum  <= '0;
                        r_idx   <= '0;
                    end
                end
                S_COUNT: begin
                    if (w_accept) begin
                        if (w_bad_count) begin
                            r_state   <= S_ERR;
                            r_err     <= 1'b1;
                            r_cpu_rst <= 1'b1;
                        end else begin
                            r_count <= IDX_W'(in_data);
                            r_state <= S_HI;
                        end
                    end
                end
                S_HI: begin
                    if (w_accept) begin
                        r_mem_wdata[15:8] <= in_data;
                        r_csum            <= r_csum ^ in_data;
                        r_state           <= S_LO;
                    end
                end
                S_LO: begin
                    if (w_accept) begin
                        r_mem_wdata[7:0] <= in_data;
                        r_csum           <= r_csum ^ in_data;
                        r_mem_addr       <= r_idx[ADDR_W-1:0];
                        r_mem_we         <= 1'b1;
                        r_in_ready       <= 1'b0;
                        r_state          <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    r_idx   <= w_idx_next;
                    r_state <= (w_idx_next == r_count) ? S_CHK : S_HI;
                end
                S_CHK: begin
                    if (w_accept) begin
                        if (in_data == r_csum) begin
                            r_state   <= S_DONE;
                            r_done    <= 1'b1;
                            r_cpu_rst <= 1'b0;
                        end else begin
                            r_state   <= S_ERR;
                            r_err     <= 1'b1;
                            r_cpu_rst <= 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    if (w_accept && w_sync) begin
                        r_state   <= S_COUNT;
                        r_cpu_rst <= 1'b1;
                        r_done    <= 1'b0;
                        r_csum    <= '0;
                        r_idx     <= '0;
                    end
                end
                S_ERR: begin
                    if (w_accept && w_sync) begin
                        r_state <= S_COUNT;
                        r_err   <= 1'b0;
                        r_csum  <= '0;
                        r_idx   <= '0;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign cpu_rst   = r_cpu_rst;
    assign done      = r_done;
    assign err       = r_err;

endmodule

// File: tb/tb_attopu_loader.sv
// tb/tb_attopu_loader.sv - self-checking bench for attopu_loader
module tb_attopu_loader;

    localparam int ADDR_W = 8;

    typedef logic [7:0]  bq_t[$];
    typedef logic [15:0] wq_t[$];

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              cpu_rst;
    logic              done;
    logic              err;

    int checks = 0;
    int errors = 0;
    int ready_bad = 0;
    int cyc = 0;

    logic [ADDR_W-1:0] log_addr[$];
    logic [15:0]       log_data[$];
    logic [15:0]       tb_mem[256];
    logic [15:0]       exp_mem[256];

    always #5 clk = ~clk;

    attopu_loader #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst   (cpu_rst),
        .done      (done),
        .err       (err)
    );

    always @(posedge clk) begin
        if (!rst) cyc = 0;
        else if (cyc < 1000) cyc = cyc + 1;
    end

    // Memory the loader writes into; captures one word per strobe.
    always @(negedge clk) begin
        if (rst && mem_we) begin
            log_addr.push_back(mem_addr);
            log_data.push_back(mem_wdata);
            tb_mem[mem_addr] = mem_wdata;
        end
        if (rst && cyc > 0 && in_ready !== !mem_we) ready_bad = ready_bad + 1;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    function automatic bq_t build_frame(input wq_t w, input bit bad);
        bq_t q;
        logic [7:0] x;
        x = 8'h00;
        q.push_back(8'hA5);
        q.push_back(8'(w.size()));
        foreach (w[i]) begin
            q.push_back(w[i][15:8]);
            q.push_back(w[i][7:0]);
            x = x ^ w[i][15:8] ^ w[i][7:0];
        end
        q.push_back(bad ? ~x : x);
        return q;
    endfunction

    function automatic logic [23:0] log_entry(input int i);
        if (i < log_addr.size()) return {log_addr[i], log_data[i]};
        return 24'hxxxxxx;
    endfunction

    task automatic clear_log();
        log_addr.delete();
        log_data.delete();
    endtask

    task automatic send_bytes(input bq_t q, input int gap_pct);
        foreach (q[k]) begin
            bit acc;
            int budget;
            acc = 1'b0;
            budget = 64;
            while (!acc && budget > 0) begin
                @(negedge clk);
                if (gap_pct > 0 && $urandom_range(99) < gap_pct) begin
                    in_valid = 1'b0;
                    in_data  = 8'($urandom);
                end else begin
                    in_valid = 1'b1;
                    in_data  = q[k];
                    acc = (in_ready === 1'b1);
                end
                budget--;
            end
            if (!acc) begin
                checks++; errors++;
                $display("FAIL send_timeout byte %0d: accepted=0 required=1", k);
            end
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (cpu_rst !== 1'b1) begin errors++; $display("FAIL reset_cpu_rst: got %b expected 1", cpu_rst); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b expected 0", mem_we); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready: got %b expected 0", in_ready); end
        checks++; if (mem_addr !== 8'h00 || mem_wdata !== 16'h0000) begin
            errors++; $display("FAIL reset_mem_bus: got %h/%h expected 00/0000", mem_addr, mem_wdata);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL release_in_ready: got %b expected 1", in_ready); end
    endtask

    task automatic test_good_load();
        bq_t q;
        q = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        clear_log();
        send_bytes(q, 0);
        exp_mem[0] = 16'h1234; exp_mem[1] = 16'hABCD;
        checks++; if (log_addr.size() != 2) begin errors++; $display("FAIL good_write_count: got %0d expected 2", log_addr.size()); end
        checks++; if (log_entry(0) !== 24'h00_1234) begin errors++; $display("FAIL good_write0: got %h expected 001234", log_entry(0)); end
        checks++; if (log_entry(1) !== 24'h01_ABCD) begin errors++; $display("FAIL good_write1: got %h expected 01abcd", log_entry(1)); end
        checks++; if ({done, cpu_rst, err} !== 3'b100) begin
            errors++; $display("FAIL good_status: got done/cpu_rst/err=%b%b%b expected 100", done, cpu_rst, err);
        end
    endtask

    task automatic test_bad_checksum();
        bq_t q;
        q = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h41};
        clear_log();
        send_bytes(q, 0);
        checks++; if (log_entry(0) !== 24'h00_1234 || log_entry(1) !== 24'h01_ABCD || log_addr.size() != 2) begin
            errors++; $display("FAIL badck_writes: got n=%0d %h %h expected n=2 001234 01abcd", log_addr.size(), log_entry(0), log_entry(1));
        end
        checks++; if ({done, cpu_rst, err} !== 3'b011) begin
            errors++; $display("FAIL badck_status: got done/cpu_rst/err=%b%b%b expected 011", done, cpu_rst, err);
        end
        q = '{8'hA5, 8'h01, 8'h00, 8'h0F, 8'h0F};
        clear_log();
        send_bytes(q, 0);
        exp_mem[0] = 16'h000F;
        checks++; if (log_entry(0) !== 24'h00_000F || log_addr.size() != 1) begin
            errors++; $display("FAIL recover_write: got n=%0d %h expected n=1 00000f", log_addr.size(), log_entry(0));
        end
        checks++; if ({done, cpu_rst, err} !== 3'b100) begin
            errors++; $display("FAIL recover_status: got done/cpu_rst/err=%b%b%b expected 100", done, cpu_rst, err);
        end
    endtask

    task automatic test_garbage_and_bad_count();
        bq_t q;
        q = '{8'h00, 8'hFF, 8'h5A};
        clear_log();
        send_bytes(q, 0);
        checks++; if (log_addr.size() != 0 || done !== 1'b1) begin
            errors++; $display("FAIL garbage_ignored: got writes=%0d done=%b expected 0 1", log_addr.size(), done);
        end
        q = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h40};
        send_bytes(q, 0);
        exp_mem[0] = 16'h1234; exp_mem[1] = 16'hABCD;
        checks++; if (log_addr.size() != 2 || log_entry(0) !== 24'h00_1234 || log_entry(1) !== 24'h01_ABCD || done !== 1'b1) begin
            errors++; $display("FAIL garbage_then_load: got n=%0d %h %h done=%b expected n=2 001234 01abcd 1",
                               log_addr.size(), log_entry(0), log_entry(1), done);
        end
        q = '{8'hA5, 8'h00};
        clear_log();
        send_bytes(q, 0);
        checks++; if ({done, cpu_rst, err} !== 3'b011 || log_addr.size() != 0) begin
            errors++; $display("FAIL zero_count: got done/cpu_rst/err=%b%b%b writes=%0d expected 011 0", done, cpu_rst, err, log_addr.size());
        end
    endtask

    task automatic test_backpressure();
        for (int p = 0; p < 2; p++) begin
            wq_t w;
            bq_t q;
            int n;
            logic [15:0] snap[256];
            n = (p == 0) ? 255 : int'($urandom_range(1, 24));
            for (int i = 0; i < n; i++) w.push_back(16'($urandom));
            q = build_frame(w, 1'b0);
            for (int g = 0; g < 2; g++) begin
                int rb0;
                int bad;
                rb0 = ready_bad;
                bad = 0;
                clear_log();
                send_bytes(q, g * 40);
                for (int i = 0; i < n; i++) begin
                    exp_mem[i] = w[i];
                    if (log_entry(i) !== {8'(i), w[i]}) bad++;
                end
                checks++; if (log_addr.size() != n || bad != 0) begin
                    errors++; $display("FAIL stream_n%0d_gap%0d: got writes=%0d wrong=%0d expected writes=%0d wrong=0", n, g, log_addr.size(), bad, n);
                end
                checks++; if (ready_bad != rb0) begin
                    errors++; $display("FAIL ready_vs_write_n%0d_gap%0d: got %0d cycles off expected 0", n, g, ready_bad - rb0);
                end
                checks++; if ({done, cpu_rst, err} !== 3'b100) begin
                    errors++; $display("FAIL stream_status_n%0d: got %b%b%b expected 100", n, done, cpu_rst, err);
                end
                if (g == 0) begin
                    snap = tb_mem;
                end else begin
                    bad = 0;
                    for (int a = 0; a < 256; a++) if (tb_mem[a] !== snap[a]) bad++;
                    checks++; if (bad != 0) begin
                        errors++; $display("FAIL gap_image_n%0d: got %0d differing words expected 0", n, bad);
                    end
                end
            end
        end
    endtask

    task automatic test_random_bad_frame();
        wq_t w;
        bq_t q;
        int n;
        int bad;
        n = int'($urandom_range(1, 16));
        for (int i = 0; i < n; i++) w.push_back(16'($urandom));
        q = build_frame(w, 1'b1);
        clear_log();
        send_bytes(q, 25);
        bad = 0;
        for (int i = 0; i < n; i++) begin
            exp_mem[i] = w[i];
            if (log_entry(i) !== {8'(i), w[i]}) bad++;
        end
        checks++; if (log_addr.size() != n || bad != 0) begin
            errors++; $display("FAIL randbad_writes: got writes=%0d wrong=%0d expected writes=%0d wrong=0", log_addr.size(), bad, n);
        end
        checks++; if ({done, cpu_rst, err} !== 3'b011) begin
            errors++; $display("FAIL randbad_status: got %b%b%b expected 011", done, cpu_rst, err);
        end
    endtask

    task automatic test_reset_mid_load();
        bq_t q;
        wq_t w;
        int bad;
        q = '{8'hA5, 8'h02, 8'h12, 8'h34, 8'h56};
        clear_log();
        send_bytes(q, 0);
        exp_mem[0] = 16'h1234;
        #2 rst = 1'b0;
        #1;
        checks++; if ({mem_we, in_ready, cpu_rst, done, err} !== 5'b00100 || mem_addr !== 8'h00 || mem_wdata !== 16'h0000) begin
            errors++; $display("FAIL midreset_values: got we/rdy/cpu_rst/done/err=%b%b%b%b%b bus=%h/%h expected 00100 00/0000",
                               mem_we, in_ready, cpu_rst, done, err, mem_addr, mem_wdata);
        end
        in_valid = 1'b1;
        in_data  = 8'h78;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b1;
        checks++; if (log_addr.size() != 1 || log_entry(0) !== 24'h00_1234) begin
            errors++; $display("FAIL midreset_writes: got n=%0d %h expected n=1 001234", log_addr.size(), log_entry(0));
        end

        q = '{8'hA5, 8'h01, 8'h77};
        clear_log();
        send_bytes(q, 0);
        in_valid = 1'b1;
        in_data  = 8'h88;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++; if ({mem_we, in_ready} !== 2'b10 || mem_addr !== 8'h00 || mem_wdata !== 16'h7788) begin
            errors++; $display("FAIL write_latency: got we/rdy=%b%b bus=%h/%h expected 10 00/7788", mem_we, in_ready, mem_addr, mem_wdata);
        end
        #1 rst = 1'b0;
        #1;
        checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL async_we_drop: got %b expected 0", mem_we); end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        checks++; if (log_addr.size() != 0) begin errors++; $display("FAIL aborted_write: got %0d writes expected 0", log_addr.size()); end

        for (int i = 0; i < 3; i++) w.push_back(16'($urandom));
        q = build_frame(w, 1'b0);
        clear_log();
        send_bytes(q, 0);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            exp_mem[i] = w[i];
            if (log_entry(i) !== {8'(i), w[i]}) bad++;
        end
        checks++; if (log_addr.size() != 3 || bad != 0 || {done, cpu_rst, err} !== 3'b100) begin
            errors++; $display("FAIL post_reset_load: got writes=%0d wrong=%0d status=%b%b%b expected 3 0 100",
                               log_addr.size(), bad, done, cpu_rst, err);
        end
    endtask

    task automatic test_memory_image();
        int bad;
        bad = 0;
        for (int a = 0; a < 256; a++) if (tb_mem[a] !== exp_mem[a]) bad++;
        checks++; if (bad != 0) begin errors++; $display("FAIL memory_image: got %0d differing words expected 0", bad); end
        checks++; if (ready_bad != 0) begin errors++; $display("FAIL ready_global: got %0d cycles off expected 0", ready_bad); end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) begin
            tb_mem[a]  = 16'h0000;
            exp_mem[a] = 16'h0000;
        end
        test_reset();
        test_good_load();
        test_bad_checksum();
        test_garbage_and_bad_count();
        test_backpressure();
        test_random_bad_frame();
        test_reset_mid_load();
        test_memory_image();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
